// File: rtl/systolic_pkg.sv
// Shared types and default sizes for the systolic array feeder.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      STREAM,
      DRAIN,
      DONE
   } feeder_state_t;

   localparam int N_DEF     = 3;
   localparam int DEPTH_DEF = 8;
   localparam int DW_DEF    = 16;
   localparam int CNT_W     = 8;

endpackage

// File: rtl/feeder_skew_gen.sv
// Diagonal read-enable mask: lane i is active for t in [i, i+K).
module feeder_skew_gen
   import systolic_pkg::*;
#(
   parameter int N  = N_DEF,
   parameter int TW = CNT_W,
   parameter int KW = 4
) (
   input  logic [TW-1:0] t,
   input  logic [KW-1:0] k,
   output logic [N-1:0]  mask
);

   for (genvar i = 0; i < N; i++) begin : g_lane
      assign mask[i] = (int'(t) >= i) && (int'(t) < i + int'(k));
   end

endmodule

// File: rtl/systolic_array_feeder.sv
// Write/skew controller feeding row and column FIFOs of an NxN systolic array.
// Optional busy-cycle counter enabled by FEEDER_PERF_CNT_EN.
module systolic_array_feeder
   import systolic_pkg::*;
#(
   parameter int N          = N_DEF,
   parameter int DEPTH      = DEPTH_DEF,
   parameter int DATA_WIDTH = DW_DEF,
   parameter int DRAIN_CYC  = 4,
   localparam int KW        = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [KW-1:0]           k_len,
   input  logic                    a_valid,
   output logic                    a_ready,
   input  logic [DATA_WIDTH-1:0]   a_data,
   input  logic                    b_valid,
   output logic                    b_ready,
   input  logic [DATA_WIDTH-1:0]   b_data,
   output logic [N-1:0]            row_w_en,
   output logic [N*DATA_WIDTH-1:0] row_wdata,
   output logic [N-1:0]            col_w_en,
   output logic [N*DATA_WIDTH-1:0] col_wdata,
   output logic [N-1:0]            row_r_en,
   output logic [N-1:0]            col_r_en,
   output logic                    busy,
   output logic                    done,
`ifdef FEEDER_PERF_CNT_EN
   output logic [31:0]             cycle_cnt,
`endif
   output logic                    err
);

   localparam int RW = $clog2(N + 1);
   localparam int TW = CNT_W;

   feeder_state_t state, next_state;

   logic [KW-1:0] k_q;
   logic [RW-1:0] a_row, b_row;
   logic [KW-1:0] a_k, b_k;
   logic          a_done, b_done;
   logic [TW-1:0] cnt;
   logic [N-1:0]  mask;
   logic          k_ok, accept, a_fire, b_fire;

   assign k_ok    = (k_len != '0) && (k_len <= KW'(DEPTH));
   assign accept  = (state == IDLE) && start && k_ok;
   assign a_ready = (state == LOAD) && !a_done;
   assign b_ready = (state == LOAD) && !b_done;
   assign a_fire  = a_valid && a_ready;
   assign b_fire  = b_valid && b_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:   if (accept) next_state = LOAD;
         LOAD:   if (a_done && b_done) next_state = STREAM;
         STREAM: if (cnt == TW'(k_q) + TW'(N - 2)) next_state = DRAIN;
         DRAIN:  if (cnt == TW'(DRAIN_CYC + N - 2)) next_state = DONE;
         DONE:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // (row,k) counters walk the row-major A / column-major B beat order
   always_ff @(posedge clk) begin
      if (rst) begin
         k_q    <= '0;
         a_row  <= '0;
         a_k    <= '0;
         a_done <= 1'b0;
         b_row  <= '0;
         b_k    <= '0;
         b_done <= 1'b0;
         cnt    <= '0;
         err    <= 1'b0;
      end else begin
         err <= (state == IDLE) && start && !k_ok;
         cnt <= (state != next_state) ? '0 : cnt + 1'b1;
         if (accept) begin
            k_q    <= k_len;
            a_row  <= '0;
            a_k    <= '0;
            a_done <= 1'b0;
            b_row  <= '0;
            b_k    <= '0;
            b_done <= 1'b0;
         end
         if (a_fire) begin
            if (a_k == k_q - 1'b1) begin
               a_k <= '0;
               if (a_row == RW'(N - 1)) a_done <= 1'b1;
               else                     a_row  <= a_row + 1'b1;
            end else begin
               a_k <= a_k + 1'b1;
            end
         end
         if (b_fire) begin
            if (b_k == k_q - 1'b1) begin
               b_k <= '0;
               if (b_row == RW'(N - 1)) b_done <= 1'b1;
               else                     b_row  <= b_row + 1'b1;
            end else begin
               b_k <= b_k + 1'b1;
            end
         end
      end
   end

   feeder_skew_gen #(
      .N  (N),
      .TW (TW),
      .KW (KW)
   ) u_skew (
      .t    (cnt),
      .k    (k_q),
      .mask (mask)
   );

   always_comb begin
      row_w_en  = '0;
      row_wdata = '0;
      col_w_en  = '0;
      col_wdata = '0;
      busy      = (state != IDLE);
      done      = (state == DONE);
      row_r_en  = (state == STREAM) ? mask : '0;
      col_r_en  = (state == STREAM) ? mask : '0;
      if (a_fire) begin
         row_w_en[a_row] = 1'b1;
         row_wdata[a_row*DATA_WIDTH +: DATA_WIDTH] = a_data;
      end
      if (b_fire) begin
         col_w_en[b_row] = 1'b1;
         col_wdata[b_row*DATA_WIDTH +: DATA_WIDTH] = b_data;
      end
   end

`ifdef FEEDER_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst)                           cycle_cnt <= '0;
      else if (accept)                   cycle_cnt <= '0;
      else if (busy && cycle_cnt != '1)  cycle_cnt <= cycle_cnt + 1'b1;
   end
`endif

endmodule
